// File: rtl/sensor_link_pkg.sv
// rtl/sensor_link_pkg.sv - shared frame layout, FSM states and reset defaults for the sensor serial link
package sensor_link_pkg;

    localparam int FRAME_BITS   = 16;
    localparam int DATA_BITS    = 13;
    localparam int FIELD_W      = 6;
    localparam int TEMP_LSB     = 0;
    localparam int LUME_LSB     = 6;
    localparam int MOTION_BIT   = 12;
    localparam int TEMP_RST_DEF = 22;
    localparam int LUME_RST_DEF = 20;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Even parity: data bits plus the parity bit must XOR to zero.
    function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
        return ~(^{data, par});
    endfunction

endpackage

// File: rtl/sensor_bit_timer.sv
// rtl/sensor_bit_timer.sv - rx_line synchroniser, falling-edge detect and bit-period down-counter
module sensor_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_line,
    input  logic load_half,
    input  logic run,
    output logic rxs,
    output logic fall,
    output logic tick
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] FULL = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2 - 1);

    logic         sync1;
    logic         rxs_d;
    logic [W-1:0] cnt;

    // Synchroniser flops reset to the idle-high line level so no edge is seen out of reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= rx_line;
            rxs   <= sync1;
            rxs_d <= rxs;
            if (load_half) begin
                cnt <= HALF;
            end else if (run) begin
                cnt <= (cnt == '0) ? FULL : cnt - 1'b1;
            end
        end
    end

    assign fall = rxs_d & ~rxs;
    assign tick = run & (cnt == '0);

endmodule

// File: rtl/sensor_frame_rx.sv
// rtl/sensor_frame_rx.sv - 16-bit sensor frame receiver with parity/framing checks and link watchdog
// Optional motion stretching over several good frames is enabled by defining MOTION_HOLD_EN.
module sensor_frame_rx
    import sensor_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int TIMEOUT_CYC  = 1024,
    parameter int TEMP_RST     = TEMP_RST_DEF,
`ifdef MOTION_HOLD_EN
    parameter int LUME_RST     = LUME_RST_DEF,
    parameter int HOLD_FRAMES  = 3
`else
    parameter int LUME_RST     = LUME_RST_DEF
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_line,
    output logic [FIELD_W-1:0] temp_sen,
    output logic [FIELD_W-1:0] lume_sen,
    output logic               motion_sen,
    output logic               frame_valid,
    output logic               frame_err,
    output logic               link_ok
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);

    rx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [3:0]           bit_cnt;
    logic                 par_bit;
    logic [WD_W-1:0]      wd_cnt;
    logic                 rxs;
    logic                 fall;
    logic                 tick;
    logic                 run;
    logic                 load_half;

`ifdef MOTION_HOLD_EN
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    logic [HOLD_W-1:0] hold_cnt;
`endif

    assign run       = (state != IDLE) && (state != WAIT_IDLE);
    assign load_half = (state == IDLE) && fall;

    sensor_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .rx_line  (rx_line),
        .load_half(load_half),
        .run      (run),
        .rxs      (rxs),
        .fall     (fall),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            par_bit     <= 1'b0;
            wd_cnt      <= '0;
            temp_sen    <= FIELD_W'(TEMP_RST);
            lume_sen    <= FIELD_W'(LUME_RST);
            motion_sen  <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            link_ok     <= 1'b0;
`ifdef MOTION_HOLD_EN
            hold_cnt    <= '0;
`endif
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            // Watchdog; a commit further down overrides these assignments.
            if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                link_ok    <= 1'b0;
                motion_sen <= 1'b0;
`ifdef MOTION_HOLD_EN
                hold_cnt   <= '0;
`endif
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state   <= START;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) state <= rxs ? IDLE : DATA;
                end
                DATA: begin
                    if (tick) begin
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'(DATA_BITS - 1)) state <= PARITY;
                    end
                end
                PARITY: begin
                    if (tick) begin
                        par_bit <= rxs;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (!rxs) begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end else if (!even_parity_ok(shreg, par_bit)) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            frame_valid <= 1'b1;
                            temp_sen    <= shreg[TEMP_LSB +: FIELD_W];
                            lume_sen    <= shreg[LUME_LSB +: FIELD_W];
                            wd_cnt      <= '0;
                            link_ok     <= 1'b1;
                            state       <= IDLE;
`ifdef MOTION_HOLD_EN
                            if (shreg[MOTION_BIT]) begin
                                hold_cnt   <= HOLD_W'(HOLD_FRAMES);
                                motion_sen <= 1'b1;
                            end else begin
                                motion_sen <= (hold_cnt != '0);
                                if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
                            end
`else
                            motion_sen  <= shreg[MOTION_BIT];
`endif
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_frame_rx.sv
// tb/tb_sensor_frame_rx.sv - directed and randomized frame checks against a behavioural receiver model
module tb_sensor_frame_rx;

    localparam int CPB  = 8;
    localparam int TO   = 1024;
    localparam int HOLD = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_line = 1'b1;
    logic [5:0] temp_sen;
    logic [5:0] lume_sen;
    logic       motion_sen;
    logic       frame_valid;
    logic       frame_err;
    logic       link_ok;

    int vectors = 0;
    int miscompares = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int fv0, fe0;

    int exp_t, exp_l, exp_m, exp_link, since;

    sensor_frame_rx #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_line    (rx_line),
        .temp_sen   (temp_sen),
        .lume_sen   (lume_sen),
        .motion_sen (motion_sen),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .link_ok    (link_ok)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
        if (frame_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_t = 22; exp_l = 20; exp_m = 0; exp_link = 0; since = 1000;
    endtask

    task automatic model_good(input int t, input int l, input int m);
        exp_t = t; exp_l = l; exp_link = 1;
`ifdef MOTION_HOLD_EN
        if (m != 0) since = 0;
        else since = since + 1;
        exp_m = (since <= HOLD) ? 1 : 0;
`else
        exp_m = m;
`endif
    endtask

    task automatic model_link_lost();
        exp_link = 0; exp_m = 0; since = 1000;
    endtask

    task automatic snap();
        fv0 = fv_cnt; fe0 = fe_cnt;
    endtask

    task automatic idle(input int n);
        rx_line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [5:0] t, input logic [5:0] l, input logic m, input logic flip);
        logic [15:0] f;
        logic p;
        p = (^{m, l, t}) ^ flip;
        f = {1'b1, p, m, l, t, 1'b0};
        for (int i = 0; i < 16; i++) begin
            rx_line = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx_line = 1'b1;
    endtask

    task automatic check_outs(input string tag, input int dfv, input int dfe);
        check({tag, "_fv"}, fv_cnt - fv0, dfv);
        check({tag, "_fe"}, fe_cnt - fe0, dfe);
        check({tag, "_temp"}, temp_sen, exp_t);
        check({tag, "_lume"}, lume_sen, exp_l);
        check({tag, "_motion"}, motion_sen, exp_m);
        check({tag, "_link"}, link_ok, exp_link);
    endtask

    task automatic good(input string tag, input int t, input int l, input int m);
        snap();
        send_frame(6'(t), 6'(l), 1'(m), 1'b0);
        idle(16);
        model_good(t, l, m);
        check_outs(tag, 1, 0);
    endtask

    initial begin
        logic [5:0] rt, rl;
        logic rm, rflip, prev_flip;

        model_reset();
        reset = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        idle(4);
        check("rst_temp", temp_sen, 22);
        check("rst_lume", lume_sen, 20);
        check("rst_motion", motion_sen, 0);
        check("rst_fv", frame_valid, 0);
        check("rst_fe", frame_err, 0);
        check("rst_link", link_ok, 0);

        good("good", 35, 17, 1);

        // Back-to-back: no idle between stop bit and next start bit
        snap();
        send_frame(6'd14, 6'd17, 1'b1, 1'b0); model_good(14, 17, 1);
        send_frame(6'd31, 6'd11, 1'b1, 1'b0); model_good(31, 11, 1);
        send_frame(6'd21, 6'd14, 1'b0, 1'b0); model_good(21, 14, 0);
        idle(16);
        check_outs("b2b", 3, 0);

        snap();
        send_frame(6'd32, 6'd16, 1'b1, 1'b1);
        idle(16);
        check_outs("parity", 0, 1);

        snap();
        rx_line = 1'b0;
        repeat (2) @(negedge clk);
        idle(40);
        check("glitch_fv", fv_cnt - fv0, 0);
        check("glitch_fe", fe_cnt - fe0, 0);

        snap();
        rx_line = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        idle(40);
        check("break_fe", fe_cnt - fe0, 1);
        check("break_fv", fv_cnt - fv0, 0);
        good("after_break", 13, 12, 1);

        snap();
        idle(TO + 20);
        model_link_lost();
        check_outs("wdog", 0, 0);
        good("wdog_recover", 26, 9, 1);

        // Abandon a frame partway through its data bits
        snap();
        send_frame(6'd5, 6'd5, 1'b1, 1'b0);
        snap();
        rx_line = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_line = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        rx_line = 1'b0;
        repeat (CPB) @(negedge clk);
        reset = 1'b0;
        rx_line = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(40);
        model_reset();
        check_outs("midrst", 0, 0);
        good("post_rst", 35, 9, 1);

        prev_flip = 1'b0;
        for (int k = 0; k < 24; k++) begin
            rt = 6'($urandom_range(0, 63));
            rl = 6'($urandom_range(0, 63));
            rm = 1'($urandom_range(0, 1));
            rflip = (!prev_flip) && ($urandom_range(0, 3) == 0);
            prev_flip = rflip;
            snap();
            send_frame(rt, rl, rm, rflip);
            idle(16 + int'($urandom_range(0, 20)));
            if (!rflip) model_good(rt, rl, rm);
            check_outs("rand", rflip ? 0 : 1, rflip ? 1 : 0);
        end

        check("no_overlap", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
